// File: rtl/link_mm_pkg.sv
// Shared types and constants for the link MM register-bus arbiter.
package link_mm_pkg;
  localparam int unsigned MM_ADDR_W = 17;
  localparam int unsigned MM_DATA_W = 64;
  localparam logic [31:0] RD_TIMEOUT_PAT = 32'hDEAD_0BAD;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    FLUSH   = 2'd2
  } link_mm_state_e;
endpackage

// File: rtl/link_mm_arbiter_if.sv
// Bundle of both requester ports and the decoder-side MM port.
// slave = arbiter view, master = requesters/decoder view.
interface link_mm_arbiter_if
  import link_mm_pkg::*;
#(
  parameter int unsigned ADDR_W = MM_ADDR_W,
  parameter int unsigned DATA_W = MM_DATA_W
);
  logic              P0_REQ, P1_REQ;
  logic              P0_WR, P1_WR;
  logic [ADDR_W-1:0] P0_ADDR, P1_ADDR;
  logic [DATA_W-1:0] P0_WR_DATA, P1_WR_DATA;
  logic              P0_GNT, P1_GNT;
  logic [DATA_W-1:0] P0_RD_DATA, P1_RD_DATA;
  logic              P0_RD_DATA_V, P1_RD_DATA_V;
  logic              P0_RD_ERR, P1_RD_ERR;
  logic [ADDR_W-1:0] oMM_ADDR;
  logic              oMM_WR_EN, oMM_RD_EN;
  logic [DATA_W-1:0] oMM_WR_DATA;
  logic [DATA_W-1:0] iMM_RD_DATA;
  logic              iMM_RD_DATA_V;

  modport slave (
    input  P0_REQ, P1_REQ, P0_WR, P1_WR, P0_ADDR, P1_ADDR, P0_WR_DATA, P1_WR_DATA,
    input  iMM_RD_DATA, iMM_RD_DATA_V,
    output P0_GNT, P1_GNT, P0_RD_DATA, P1_RD_DATA, P0_RD_DATA_V, P1_RD_DATA_V,
    output P0_RD_ERR, P1_RD_ERR, oMM_ADDR, oMM_WR_EN, oMM_RD_EN, oMM_WR_DATA
  );

  modport master (
    output P0_REQ, P1_REQ, P0_WR, P1_WR, P0_ADDR, P1_ADDR, P0_WR_DATA, P1_WR_DATA,
    output iMM_RD_DATA, iMM_RD_DATA_V,
    input  P0_GNT, P1_GNT, P0_RD_DATA, P1_RD_DATA, P0_RD_DATA_V, P1_RD_DATA_V,
    input  P0_RD_ERR, P1_RD_ERR, oMM_ADDR, oMM_WR_EN, oMM_RD_EN, oMM_WR_DATA
  );
endinterface

// File: rtl/link_mm_rr2.sv
// Two-way round-robin picker: one-hot winner from an eligible vector.
module link_mm_rr2 (
  input  logic [1:0] i_elig,
  input  logic       i_last,   // 1 = P1 was granted last
  output logic [1:0] o_win
);
  always_comb begin
    o_win = i_elig;
    if (&i_elig) o_win = i_last ? 2'b01 : 2'b10;
  end
endmodule

// File: rtl/link_mm_arbiter.sv
// Round-robin arbiter/sequencer sharing one MM port between P0 and P1.
// Optional read timeout and FLUSH drain under `LINK_MM_ARB_TIMEOUT_EN.
module link_mm_arbiter
  import link_mm_pkg::*;
#(
  parameter int unsigned ADDR_W     = MM_ADDR_W,
  parameter int unsigned DATA_W     = MM_DATA_W,
  parameter int unsigned RD_TIMEOUT = 64
) (
  input logic               clk,
  input logic               rst_n,
  link_mm_arbiter_if.slave  mm
);
  link_mm_state_e         r_state, w_state_nxt;
  logic                   r_last, w_last_nxt;
  logic                   r_owner, w_owner_nxt;
  logic [1:0]             r_gnt, w_gnt_nxt;
  logic [1:0]             r_rd_v, w_rd_v_nxt;
  logic [1:0][DATA_W-1:0] r_rd_data, w_rd_data_nxt;
  logic [ADDR_W-1:0]      r_mm_addr, w_mm_addr_nxt;
  logic [DATA_W-1:0]      r_mm_wr_data, w_mm_wr_data_nxt;
  logic                   r_wr_en, w_wr_en_nxt;
  logic                   r_rd_en, w_rd_en_nxt;
  logic [1:0]             w_elig, w_win;
  logic                   w_sel;

`ifdef LINK_MM_ARB_TIMEOUT_EN
  localparam int unsigned     CNT_W    = $clog2(RD_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [1:0]        r_rd_err, w_rd_err_nxt;
  logic [DATA_W-1:0] w_err_data;
  // r_mm_addr still holds the read address: no grants happen in RD_WAIT.
  assign w_err_data = {RD_TIMEOUT_PAT, {(DATA_W-32){1'b0}}} | DATA_W'(r_mm_addr);
`endif

  // A requester whose GNT is currently high is not eligible again.
  assign w_elig = {mm.P1_REQ & ~r_gnt[1], mm.P0_REQ & ~r_gnt[0]};
  assign w_sel  = w_win[1];

  link_mm_rr2 u_rr2 (
    .i_elig (w_elig),
    .i_last (r_last),
    .o_win  (w_win)
  );

  always_comb begin
    w_state_nxt      = r_state;
    w_last_nxt       = r_last;
    w_owner_nxt      = r_owner;
    w_gnt_nxt        = '0;
    w_rd_v_nxt       = '0;
    w_rd_data_nxt    = r_rd_data;
    w_mm_addr_nxt    = r_mm_addr;
    w_mm_wr_data_nxt = r_mm_wr_data;
    w_wr_en_nxt      = 1'b0;
    w_rd_en_nxt      = 1'b0;
`ifdef LINK_MM_ARB_TIMEOUT_EN
    w_cnt_nxt        = r_cnt;
    w_rd_err_nxt     = '0;
`endif
    case (r_state)
      IDLE: begin
        if (|w_win) begin
          w_gnt_nxt     = w_win;
          w_last_nxt    = w_sel;
          w_mm_addr_nxt = w_sel ? mm.P1_ADDR : mm.P0_ADDR;
          if (w_sel ? mm.P1_WR : mm.P0_WR) begin
            w_wr_en_nxt      = 1'b1;
            w_mm_wr_data_nxt = w_sel ? mm.P1_WR_DATA : mm.P0_WR_DATA;
          end else begin
            w_rd_en_nxt = 1'b1;
            w_owner_nxt = w_sel;
            w_state_nxt = RD_WAIT;
`ifdef LINK_MM_ARB_TIMEOUT_EN
            w_cnt_nxt   = '0;
`endif
          end
        end
      end
      RD_WAIT: begin
        if (mm.iMM_RD_DATA_V) begin
          w_rd_data_nxt[r_owner] = mm.iMM_RD_DATA;
          w_rd_v_nxt[r_owner]    = 1'b1;
          w_state_nxt            = IDLE;
        end
`ifdef LINK_MM_ARB_TIMEOUT_EN
        else if (r_cnt == CNT_LAST) begin
          w_rd_data_nxt[r_owner] = w_err_data;
          w_rd_v_nxt[r_owner]    = 1'b1;
          w_rd_err_nxt[r_owner]  = 1'b1;
          w_cnt_nxt              = '0;
          w_state_nxt            = FLUSH;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
`endif
      end
`ifdef LINK_MM_ARB_TIMEOUT_EN
      FLUSH: begin
        if (r_cnt == CNT_LAST) w_state_nxt = IDLE;
        else                   w_cnt_nxt   = r_cnt + 1'b1;
      end
`endif
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_last       <= 1'b1;
      r_owner      <= 1'b0;
      r_gnt        <= '0;
      r_rd_v       <= '0;
      r_rd_data    <= '0;
      r_mm_addr    <= '0;
      r_mm_wr_data <= '0;
      r_wr_en      <= 1'b0;
      r_rd_en      <= 1'b0;
`ifdef LINK_MM_ARB_TIMEOUT_EN
      r_cnt        <= '0;
      r_rd_err     <= '0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_last       <= w_last_nxt;
      r_owner      <= w_owner_nxt;
      r_gnt        <= w_gnt_nxt;
      r_rd_v       <= w_rd_v_nxt;
      r_rd_data    <= w_rd_data_nxt;
      r_mm_addr    <= w_mm_addr_nxt;
      r_mm_wr_data <= w_mm_wr_data_nxt;
      r_wr_en      <= w_wr_en_nxt;
      r_rd_en      <= w_rd_en_nxt;
`ifdef LINK_MM_ARB_TIMEOUT_EN
      r_cnt        <= w_cnt_nxt;
      r_rd_err     <= w_rd_err_nxt;
`endif
    end
  end

  assign mm.P0_GNT       = r_gnt[0];
  assign mm.P1_GNT       = r_gnt[1];
  assign mm.P0_RD_DATA_V = r_rd_v[0];
  assign mm.P1_RD_DATA_V = r_rd_v[1];
  assign mm.P0_RD_DATA   = r_rd_data[0];
  assign mm.P1_RD_DATA   = r_rd_data[1];
  assign mm.oMM_ADDR     = r_mm_addr;
  assign mm.oMM_WR_DATA  = r_mm_wr_data;
  assign mm.oMM_WR_EN    = r_wr_en;
  assign mm.oMM_RD_EN    = r_rd_en;
`ifdef LINK_MM_ARB_TIMEOUT_EN
  assign mm.P0_RD_ERR    = r_rd_err[0];
  assign mm.P1_RD_ERR    = r_rd_err[1];
`else
  assign mm.P0_RD_ERR    = 1'b0;
  assign mm.P1_RD_ERR    = 1'b0;
`endif
endmodule

// File: tb/tb_link_mm_arbiter.sv
// Directed self-checking bench for link_mm_arbiter; timeout scenarios
// run only when LINK_MM_ARB_TIMEOUT_EN is defined (RD_TIMEOUT = 8).
module tb_link_mm_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  link_mm_arbiter_if #(.ADDR_W(17), .DATA_W(64)) bus ();

  link_mm_arbiter #(.ADDR_W(17), .DATA_W(64), .RD_TIMEOUT(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mm    (bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_reset(input string tag);
    logic [7:0] flags;
    flags = {bus.P0_GNT, bus.P1_GNT, bus.P0_RD_DATA_V, bus.P1_RD_DATA_V,
             bus.P0_RD_ERR, bus.P1_RD_ERR, bus.oMM_WR_EN, bus.oMM_RD_EN};
    if (flags !== 8'h00) begin
      $display("FAIL %s_strobes: got %b want 00000000", tag, flags); bad++;
    end
    total++;
    if (bus.oMM_ADDR !== 17'h0) begin
      $display("FAIL %s_addr: got %h want 0", tag, bus.oMM_ADDR); bad++;
    end
    total++;
    if (bus.oMM_WR_DATA !== 64'h0) begin
      $display("FAIL %s_wdata: got %h want 0", tag, bus.oMM_WR_DATA); bad++;
    end
    total++;
    if ({bus.P0_RD_DATA, bus.P1_RD_DATA} !== 128'h0) begin
      $display("FAIL %s_rdata: got %h %h want 0", tag, bus.P0_RD_DATA, bus.P1_RD_DATA); bad++;
    end
    total++;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick(); tick();
    check_all_reset("reset");
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_dual_write;
    bus.P0_REQ = 1; bus.P0_WR = 1; bus.P0_ADDR = 17'h00010; bus.P0_WR_DATA = 64'hAAAA_0000_0000_0010;
    bus.P1_REQ = 1; bus.P1_WR = 1; bus.P1_ADDR = 17'h08020; bus.P1_WR_DATA = 64'hBBBB_0000_0000_8020;
    tick();
    if ({bus.P1_GNT, bus.P0_GNT, bus.oMM_WR_EN, bus.oMM_RD_EN} !== 4'b0110) begin
      $display("FAIL dual_first_gnt: got p1/p0/wr/rd=%b want 0110",
               {bus.P1_GNT, bus.P0_GNT, bus.oMM_WR_EN, bus.oMM_RD_EN}); bad++;
    end
    total++;
    if (bus.oMM_ADDR !== 17'h00010 || bus.oMM_WR_DATA !== 64'hAAAA_0000_0000_0010) begin
      $display("FAIL dual_first_bus: got %h/%h want 00010/aaaa000000000010", bus.oMM_ADDR, bus.oMM_WR_DATA); bad++;
    end
    total++;
    bus.P0_REQ = 0;
    tick();
    if ({bus.P1_GNT, bus.P0_GNT, bus.oMM_WR_EN, bus.oMM_RD_EN} !== 4'b1010) begin
      $display("FAIL dual_second_gnt: got p1/p0/wr/rd=%b want 1010",
               {bus.P1_GNT, bus.P0_GNT, bus.oMM_WR_EN, bus.oMM_RD_EN}); bad++;
    end
    total++;
    if (bus.oMM_ADDR !== 17'h08020 || bus.oMM_WR_DATA !== 64'hBBBB_0000_0000_8020) begin
      $display("FAIL dual_second_bus: got %h/%h want 08020/bbbb000000008020", bus.oMM_ADDR, bus.oMM_WR_DATA); bad++;
    end
    total++;
    bus.P1_REQ = 0;
    tick();
    if ({bus.P1_GNT, bus.P0_GNT, bus.oMM_WR_EN} !== 3'b000) begin
      $display("FAIL dual_idle: got %b want 000", {bus.P1_GNT, bus.P0_GNT, bus.oMM_WR_EN}); bad++;
    end
    total++;
  endtask

  task automatic test_read;
    int early_v;
    early_v = 0;
    bus.P1_REQ = 1; bus.P1_WR = 0; bus.P1_ADDR = 17'h08000;
    tick();
    if ({bus.P1_GNT, bus.oMM_RD_EN, bus.oMM_WR_EN} !== 3'b110 || bus.oMM_ADDR !== 17'h08000) begin
      $display("FAIL read_issue: got gnt/rd/wr=%b addr=%h want 110 addr=08000",
               {bus.P1_GNT, bus.oMM_RD_EN, bus.oMM_WR_EN}, bus.oMM_ADDR); bad++;
    end
    total++;
    bus.P1_REQ = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.P0_RD_DATA_V | bus.P1_RD_DATA_V) early_v++;
    end
    if (early_v !== 0) begin
      $display("FAIL read_early_v: got %0d early valids want 0", early_v); bad++;
    end
    total++;
    bus.iMM_RD_DATA = 64'h1234; bus.iMM_RD_DATA_V = 1;
    tick();
    bus.iMM_RD_DATA_V = 0;
    if ({bus.P1_RD_DATA_V, bus.P1_RD_ERR, bus.P0_RD_DATA_V} !== 3'b100 || bus.P1_RD_DATA !== 64'h1234) begin
      $display("FAIL read_resp: got v1/err1/v0=%b data=%h want 100 data=1234",
               {bus.P1_RD_DATA_V, bus.P1_RD_ERR, bus.P0_RD_DATA_V}, bus.P1_RD_DATA); bad++;
    end
    total++;
    tick();
    if (bus.P1_RD_DATA_V !== 1'b0) begin
      $display("FAIL read_v_pulse: got %b want 0", bus.P1_RD_DATA_V); bad++;
    end
    total++;
  endtask

  task automatic test_hold_during_read;
    int gnt_in_wait;
    gnt_in_wait = 0;
    bus.P1_REQ = 1; bus.P1_WR = 0; bus.P1_ADDR = 17'h08008;
    tick();
    if (bus.P1_GNT !== 1'b1) begin
      $display("FAIL hold_rd_gnt: got %b want 1", bus.P1_GNT); bad++;
    end
    total++;
    bus.P1_REQ = 0;
    bus.P0_REQ = 1; bus.P0_WR = 1; bus.P0_ADDR = 17'h00100; bus.P0_WR_DATA = 64'h0C0C;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.P0_GNT | bus.oMM_WR_EN) gnt_in_wait++;
    end
    bus.iMM_RD_DATA = 64'hABCD; bus.iMM_RD_DATA_V = 1;
    tick();
    bus.iMM_RD_DATA_V = 0;
    if (bus.P0_GNT) gnt_in_wait++;
    if (gnt_in_wait !== 0) begin
      $display("FAIL hold_gnt_in_wait: got %0d grants want 0", gnt_in_wait); bad++;
    end
    total++;
    if (bus.P1_RD_DATA_V !== 1'b1 || bus.P1_RD_DATA !== 64'hABCD) begin
      $display("FAIL hold_resp: got v=%b data=%h want 1 abcd", bus.P1_RD_DATA_V, bus.P1_RD_DATA); bad++;
    end
    total++;
    tick();
    if ({bus.P0_GNT, bus.oMM_WR_EN} !== 2'b11 || bus.oMM_ADDR !== 17'h00100 || bus.oMM_WR_DATA !== 64'h0C0C) begin
      $display("FAIL hold_late_gnt: got gnt/wr=%b addr=%h data=%h want 11 00100 0c0c",
               {bus.P0_GNT, bus.oMM_WR_EN}, bus.oMM_ADDR, bus.oMM_WR_DATA); bad++;
    end
    total++;
    bus.P0_REQ = 0;
    tick();
  endtask

  task automatic test_back_to_back;
    logic [3:0] seen;
    bus.P0_REQ = 1; bus.P0_WR = 1; bus.P0_ADDR = 17'h00200; bus.P0_WR_DATA = 64'h55;
    for (int i = 0; i < 4; i++) begin
      tick();
      seen[i] = bus.P0_GNT;
    end
    bus.P0_REQ = 0;
    if (seen !== 4'b0101) begin
      $display("FAIL b2b_pattern: got %b want 0101 (lsb first cycle)", seen); bad++;
    end
    total++;
    tick();
  endtask

`ifdef LINK_MM_ARB_TIMEOUT_EN
  task automatic test_timeout;
    int early_v, gnt_in_flush;
    early_v = 0; gnt_in_flush = 0;
    bus.P0_REQ = 1; bus.P0_WR = 0; bus.P0_ADDR = 17'h1FFFF;
    tick();
    bus.P0_REQ = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (bus.P0_RD_DATA_V) early_v++;
    end
    if (early_v !== 0) begin
      $display("FAIL to_early_v: got %0d want 0", early_v); bad++;
    end
    total++;
    tick();
    if ({bus.P0_RD_DATA_V, bus.P0_RD_ERR} !== 2'b11 || bus.P0_RD_DATA !== 64'hDEAD0BAD_0001FFFF) begin
      $display("FAIL to_resp: got v/err=%b data=%h want 11 dead0bad0001ffff",
               {bus.P0_RD_DATA_V, bus.P0_RD_ERR}, bus.P0_RD_DATA); bad++;
    end
    total++;
    tick();
    bus.iMM_RD_DATA = 64'h5555; bus.iMM_RD_DATA_V = 1;
    tick();
    bus.iMM_RD_DATA_V = 0;
    if ({bus.P0_RD_DATA_V, bus.P1_RD_DATA_V} !== 2'b00) begin
      $display("FAIL to_flush_drop: got v0/v1=%b want 00", {bus.P0_RD_DATA_V, bus.P1_RD_DATA_V}); bad++;
    end
    total++;
    bus.P1_REQ = 1; bus.P1_WR = 1; bus.P1_ADDR = 17'h00300; bus.P1_WR_DATA = 64'h33;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.P1_GNT) gnt_in_flush++;
    end
    if (gnt_in_flush !== 0) begin
      $display("FAIL to_flush_gnt: got %0d want 0", gnt_in_flush); bad++;
    end
    total++;
    tick();
    bus.P1_REQ = 0;
    if (bus.P1_GNT !== 1'b1) begin
      $display("FAIL to_after_flush_gnt: got %b want 1", bus.P1_GNT); bad++;
    end
    total++;
    tick();
  endtask

  task automatic test_timeout_race;
    bus.P0_REQ = 1; bus.P0_WR = 0; bus.P0_ADDR = 17'h00200;
    tick();
    bus.P0_REQ = 0;
    for (int i = 0; i < 7; i++) tick();
    bus.iMM_RD_DATA = 64'h77; bus.iMM_RD_DATA_V = 1;
    tick();
    bus.iMM_RD_DATA_V = 0;
    if ({bus.P0_RD_DATA_V, bus.P0_RD_ERR} !== 2'b10 || bus.P0_RD_DATA !== 64'h77) begin
      $display("FAIL race_resp: got v/err=%b data=%h want 10 77",
               {bus.P0_RD_DATA_V, bus.P0_RD_ERR}, bus.P0_RD_DATA); bad++;
    end
    total++;
    bus.P1_REQ = 1; bus.P1_WR = 1; bus.P1_ADDR = 17'h00400; bus.P1_WR_DATA = 64'h44;
    tick();
    bus.P1_REQ = 0;
    if (bus.P1_GNT !== 1'b1) begin
      $display("FAIL race_no_flush: got gnt %b want 1", bus.P1_GNT); bad++;
    end
    total++;
    tick();
  endtask
`endif

  task automatic test_reset_mid_read;
    bus.P0_REQ = 1; bus.P0_WR = 0; bus.P0_ADDR = 17'h00300;
    tick();
    bus.P0_REQ = 0;
    if (bus.oMM_RD_EN !== 1'b1 || bus.oMM_ADDR !== 17'h00300) begin
      $display("FAIL rst_rd_issue: got rd=%b addr=%h want 1 00300", bus.oMM_RD_EN, bus.oMM_ADDR); bad++;
    end
    total++;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    check_all_reset("rst_async");
    bus.iMM_RD_DATA = 64'h9999; bus.iMM_RD_DATA_V = 1;
    tick();
    rst_n = 1'b1;
    tick();
    bus.iMM_RD_DATA_V = 0;
    check_all_reset("rst_late_v");
  endtask

  initial begin
    bus.P0_REQ = 0; bus.P0_WR = 0; bus.P0_ADDR = '0; bus.P0_WR_DATA = '0;
    bus.P1_REQ = 0; bus.P1_WR = 0; bus.P1_ADDR = '0; bus.P1_WR_DATA = '0;
    bus.iMM_RD_DATA = '0; bus.iMM_RD_DATA_V = 0;
    test_reset();
    test_dual_write();
    test_read();
    test_hold_during_read();
    test_back_to_back();
`ifdef LINK_MM_ARB_TIMEOUT_EN
    test_timeout();
    test_timeout_race();
`endif
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
